// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback,
// guards the memory handshake with a timeout, flags illegal encodings and counts retirements.
package mips_pkg;
    localparam logic [5:0] OP_ZERO  = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ABS   = 6'h1F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ZERO  = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_ABS = 3'd6
    } t_alu_opcode;
endpackage

module mc_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned CNT_W        = 32,
    parameter bit          TRAP_ILLEGAL = 1'b1,
    parameter bit          ABS_EN       = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_iord,
    output logic             o_ir_write,
    output logic             o_pc_en,
    output logic [1:0]       o_pc_src,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output t_alu_opcode      o_alu_control,
    output logic             o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_reg_write,
    output logic             o_illegal,
    output logic             o_bus_err,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_retired_count,
    output logic [3:0]       o_state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEX    = 4'd9,
        S_JUMP   = 4'd10,
        S_ABSEX  = 4'd11,
        S_FAULT  = 4'd12
    } t_state;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        iord;
        logic        pc_en;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [1:0]  pc_src;
        t_alu_opcode alu_op;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        reg_write;
    } t_moore;

    localparam bit                TO_EN     = (MEM_TIMEOUT != 0);
    localparam int unsigned       WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = TO_EN ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    t_state             r_state;
    t_moore             r_moore;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_bus_err;
    logic [CNT_W-1:0]   r_retired_count;
    logic               r_is_lw;
    logic               r_rtype;

    t_state             w_next;
    t_state             w_dec_next;
    t_alu_opcode        w_rex_op;
    logic               w_funct_ok;
    logic               w_nop;
    logic               w_dec_bad;
    logic               w_retire;
    logic               w_illegal;
    logic               w_timeout;
    logic               w_mem_wait;
    logic               w_limit;
    logic               w_fetch_go;

    // Moore output decode; applied to the next state so the outputs come straight from flops.
    function automatic t_moore f_moore(input t_state st, input logic rtype,
                                       input t_alu_opcode rex_op);
        t_moore m;
        m = '0;
        m.alu_op = ALU_ADD;
        case (st)
            S_FETCH: begin
                m.mem_req   = 1'b1;
                m.alu_src_b = 2'b01;
            end
            S_DECODE: m.alu_src_b = 2'b11;
            S_MEMADR, S_IEX: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                m.mem_req = 1'b1;
                m.iord    = 1'b1;
            end
            S_MEMWB: begin
                m.reg_write  = 1'b1;
                m.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                m.mem_req = 1'b1;
                m.mem_we  = 1'b1;
                m.iord    = 1'b1;
            end
            S_REX: begin
                m.alu_src_a = 1'b1;
                m.alu_op    = rex_op;
            end
            S_ALUWB: begin
                m.reg_write = 1'b1;
                m.reg_dst   = rtype;
            end
            S_BRANCH: begin
                m.alu_src_a = 1'b1;
                m.alu_op    = ALU_SUB;
                m.pc_src    = 2'b01;
            end
            S_JUMP: begin
                m.pc_src = 2'b10;
                m.pc_en  = 1'b1;
            end
            S_ABSEX: begin
                m.alu_src_a = 1'b1;
                m.alu_op    = ALU_ABS;
            end
            default: ;
        endcase
        return m;
    endfunction

    always_comb begin
        w_funct_ok = 1'b1;
        w_rex_op   = ALU_ADD;
        case (i_funct)
            FN_ADD:  w_rex_op = ALU_ADD;
            FN_SUB:  w_rex_op = ALU_SUB;
            FN_AND:  w_rex_op = ALU_AND;
            FN_OR:   w_rex_op = ALU_OR;
            FN_XOR:  w_rex_op = ALU_XOR;
            FN_SLT:  w_rex_op = ALU_SLT;
            default: w_funct_ok = 1'b0;
        endcase

        w_dec_next = S_FAULT;
        w_nop      = 1'b0;
        w_dec_bad  = 1'b0;
        case (i_opcode)
            OP_LW, OP_SW:    w_dec_next = S_MEMADR;
            OP_ZERO: begin
                if (i_funct == FN_ZERO) w_nop = 1'b1;
                else if (w_funct_ok)    w_dec_next = S_REX;
                else                    w_dec_bad = 1'b1;
            end
            OP_BEQ:          w_dec_next = S_BRANCH;
            OP_ADDI, OP_ADDIU: w_dec_next = S_IEX;
            OP_J:            w_dec_next = S_JUMP;
            OP_ABS: begin
                if (ABS_EN) w_dec_next = S_ABSEX;
                else        w_dec_bad = 1'b1;
            end
            default:         w_dec_bad = 1'b1;
        endcase
    end

    // Only the three request states wait on memory; ready on the limit cycle still wins.
    assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                        && !i_mem_ready;
    assign w_limit    = TO_EN && (r_wait_cnt == WAIT_LAST);

    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        w_illegal = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (i_mem_ready) w_next = S_DECODE;
                else if (w_limit) w_timeout = 1'b1;
            end
            S_DECODE: begin
                if (w_nop) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_dec_bad) begin
                    w_illegal = 1'b1;
                    if (TRAP_ILLEGAL) begin
                        w_next = S_FAULT;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else begin
                    w_next = w_dec_next;
                end
            end
            S_MEMADR: w_next = r_is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (i_mem_ready) w_next = S_MEMWB;
                else if (w_limit) w_timeout = 1'b1;
            end
            S_MEMWR: begin
                if (i_mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_limit) begin
                    w_timeout = 1'b1;
                end
            end
            S_REX, S_IEX, S_ABSEX: w_next = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: begin
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FAULT;
        endcase
        if (w_timeout) w_next = S_FAULT;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= S_FETCH;
            r_moore         <= f_moore(S_FETCH, 1'b0, ALU_ADD);
            r_wait_cnt      <= '0;
            r_bus_err       <= 1'b0;
            r_retired_count <= '0;
            r_is_lw         <= 1'b0;
            r_rtype         <= 1'b0;
        end else begin
            r_state <= w_next;
            r_moore <= f_moore(w_next, r_rtype, w_rex_op);
            if (w_mem_wait && TO_EN) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            else                     r_wait_cnt <= '0;
            if (w_timeout) r_bus_err <= 1'b1;
            if (w_retire)  r_retired_count <= r_retired_count + CNT_W'(1);
            if (r_state == S_DECODE) begin
                r_is_lw <= (i_opcode == OP_LW);
                r_rtype <= (i_opcode == OP_ZERO);
            end
        end
    end

    // Reset holds the FETCH decode but must not let a ready memory load IR/PC.
    assign w_fetch_go = (r_state == S_FETCH) && i_mem_ready && !i_rst;

    assign o_mem_req       = r_moore.mem_req;
    assign o_mem_we        = r_moore.mem_we;
    assign o_iord          = r_moore.iord;
    assign o_ir_write      = w_fetch_go;
    assign o_pc_en         = r_moore.pc_en || w_fetch_go || ((r_state == S_BRANCH) && i_zero);
    assign o_pc_src        = r_moore.pc_src;
    assign o_alu_src_a     = r_moore.alu_src_a;
    assign o_alu_src_b     = r_moore.alu_src_b;
    assign o_alu_control   = r_moore.alu_op;
    assign o_reg_dst       = r_moore.reg_dst;
    assign o_mem_to_reg    = r_moore.mem_to_reg;
    assign o_reg_write     = r_moore.reg_write;
    assign o_illegal       = w_illegal;
    assign o_bus_err       = r_bus_err;
    assign o_retire        = w_retire;
    assign o_retired_count = r_retired_count;
    assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: two instances (default and timeout-4 / no-trap / 4-bit counter)
// checked every cycle against an instruction-level path model.
module tb_mc_control;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] zero;
    logic [1:0] mem_ready;
    logic [5:0] opcode [2];
    logic [5:0] funct [2];

    logic a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_en, a_alu_src_a;
    logic a_reg_dst, a_mem_to_reg, a_reg_write, a_illegal, a_bus_err, a_retire;
    logic [1:0] a_pc_src, a_alu_src_b;
    t_alu_opcode a_alu_control;
    logic [31:0] a_cnt;
    logic [3:0] a_state;

    logic b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_en, b_alu_src_a;
    logic b_reg_dst, b_mem_to_reg, b_reg_write, b_illegal, b_bus_err, b_retire;
    logic [1:0] b_pc_src, b_alu_src_b;
    t_alu_opcode b_alu_control;
    logic [3:0] b_cnt;
    logic [3:0] b_state;

    mc_control dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_opcode(opcode[0]), .i_funct(funct[0]),
        .i_zero(zero[0]), .i_mem_ready(mem_ready[0]),
        .o_mem_req(a_mem_req), .o_mem_we(a_mem_we), .o_iord(a_iord), .o_ir_write(a_ir_write),
        .o_pc_en(a_pc_en), .o_pc_src(a_pc_src), .o_alu_src_a(a_alu_src_a),
        .o_alu_src_b(a_alu_src_b), .o_alu_control(a_alu_control), .o_reg_dst(a_reg_dst),
        .o_mem_to_reg(a_mem_to_reg), .o_reg_write(a_reg_write), .o_illegal(a_illegal),
        .o_bus_err(a_bus_err), .o_retire(a_retire), .o_retired_count(a_cnt),
        .o_state_dbg(a_state)
    );

    mc_control #(.MEM_TIMEOUT(4), .CNT_W(4), .TRAP_ILLEGAL(1'b0), .ABS_EN(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_opcode(opcode[1]), .i_funct(funct[1]),
        .i_zero(zero[1]), .i_mem_ready(mem_ready[1]),
        .o_mem_req(b_mem_req), .o_mem_we(b_mem_we), .o_iord(b_iord), .o_ir_write(b_ir_write),
        .o_pc_en(b_pc_en), .o_pc_src(b_pc_src), .o_alu_src_a(b_alu_src_a),
        .o_alu_src_b(b_alu_src_b), .o_alu_control(b_alu_control), .o_reg_dst(b_reg_dst),
        .o_mem_to_reg(b_mem_to_reg), .o_reg_write(b_reg_write), .o_illegal(b_illegal),
        .o_bus_err(b_bus_err), .o_retire(b_retire), .o_retired_count(b_cnt),
        .o_state_dbg(b_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_cnt [2];
    bit          berr [2];

    typedef struct {
        int st;
        bit rdy;
        bit ill;
        bit ret;
        bit to;
    } step_t;
    step_t path[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs(input int k);
        if (k == 0)
            return {13'b0, a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_en, a_pc_src, a_alu_src_a,
                    a_alu_src_b, a_alu_control, a_reg_dst, a_mem_to_reg, a_reg_write, a_illegal,
                    a_retire, a_bus_err};
        return {13'b0, b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_en, b_pc_src, b_alu_src_a,
                b_alu_src_b, b_alu_control, b_reg_dst, b_mem_to_reg, b_reg_write, b_illegal,
                b_retire, b_bus_err};
    endfunction

    function automatic logic [31:0] state_of(input int k);
        return (k == 0) ? {28'b0, a_state} : {28'b0, b_state};
    endfunction

    function automatic logic [31:0] cnt_of(input int k);
        return (k == 0) ? a_cnt : {28'b0, b_cnt};
    endfunction

    function automatic logic [31:0] cnt_mask(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
    endfunction

    function automatic bit fn_legal(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT};
    endfunction

    function automatic t_alu_opcode fn_op(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Expected outputs for a state, straight from the per-state output table.
    function automatic logic [31:0] exp_outs(input int st, input bit rtype, input t_alu_opcode rop,
                                             input bit z, input bit rdy, input bit ill,
                                             input bit ret, input bit be, input bit in_rst);
        logic mreq, mwe, iord, irw, pce, a, rd, m2r, rw;
        logic [1:0] pcs, b;
        t_alu_opcode op;
        {mreq, mwe, iord, irw, pce, a, rd, m2r, rw} = '0;
        pcs = 2'b00; b = 2'b00; op = ALU_ADD;
        case (st)
            0:  begin mreq = 1; b = 2'b01; irw = rdy && !in_rst; pce = rdy && !in_rst; end
            1:  b = 2'b11;
            2:  begin a = 1; b = 2'b10; end
            3:  begin mreq = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mreq = 1; mwe = 1; iord = 1; end
            6:  begin a = 1; op = rop; end
            7:  begin rw = 1; rd = rtype; end
            8:  begin a = 1; op = ALU_SUB; pcs = 2'b01; pce = z; end
            9:  begin a = 1; b = 2'b10; end
            10: begin pcs = 2'b10; pce = 1; end
            11: begin a = 1; op = ALU_ABS; end
            default: ;
        endcase
        return {13'b0, mreq, mwe, iord, irw, pce, pcs, a, b, op, rd, m2r, rw, ill, ret, be};
    endfunction

    function automatic bit rbit();
        return ($urandom & 1) != 0;
    endfunction

    task automatic push_step(input int st, input bit rdy, input bit ill, input bit ret, input bit to);
        step_t s;
        s.st = st; s.rdy = rdy; s.ill = ill; s.ret = ret; s.to = to;
        path.push_back(s);
    endtask

    task automatic push_fault();
        for (int i = 0; i < 3; i++) push_step(12, rbit(), 0, 0, 0);
    endtask

    // n cycles without ready in a request state, then ready (retiring if it completes a store).
    task automatic push_wait(input int st, input int n, input int lim, input bit ret_on_rdy,
                             output bit faulted);
        faulted = 0;
        if (lim != 0 && n >= lim) begin
            for (int i = 0; i < lim; i++) push_step(st, 0, 0, 0, i == lim - 1);
            push_fault();
            faulted = 1;
        end else begin
            for (int i = 0; i < n; i++) push_step(st, 0, 0, 0, 0);
            push_step(st, 1, 0, ret_on_rdy, 0);
        end
    endtask

    task automatic build_path(input int k, input logic [5:0] op, input logic [5:0] fn,
                              input int fd, input int md, output bit faulted);
        int lim;
        bit trap;
        lim  = (k == 0) ? 16 : 4;
        trap = (k == 0);
        path.delete();
        push_wait(0, fd, lim, 0, faulted);
        if (faulted) return;
        if (op == OP_LW || op == OP_SW) begin
            push_step(1, rbit(), 0, 0, 0);
            push_step(2, rbit(), 0, 0, 0);
            if (op == OP_LW) begin
                push_wait(3, md, lim, 0, faulted);
                if (!faulted) push_step(4, rbit(), 0, 1, 0);
            end else begin
                push_wait(5, md, lim, 1, faulted);
            end
        end else if (op == OP_ZERO && fn == FN_ZERO) begin
            push_step(1, rbit(), 0, 1, 0);
        end else if (op == OP_ZERO && fn_legal(fn)) begin
            push_step(1, rbit(), 0, 0, 0);
            push_step(6, rbit(), 0, 0, 0);
            push_step(7, rbit(), 0, 1, 0);
        end else if (op == OP_BEQ) begin
            push_step(1, rbit(), 0, 0, 0);
            push_step(8, rbit(), 0, 1, 0);
        end else if (op == OP_ADDI || op == OP_ADDIU || op == OP_ABS) begin
            push_step(1, rbit(), 0, 0, 0);
            push_step((op == OP_ABS) ? 11 : 9, rbit(), 0, 0, 0);
            push_step(7, rbit(), 0, 1, 0);
        end else if (op == OP_J) begin
            push_step(1, rbit(), 0, 0, 0);
            push_step(10, rbit(), 0, 1, 0);
        end else begin
            push_step(1, rbit(), 1, !trap, 0);
            if (trap) begin
                push_fault();
                faulted = 1;
            end
        end
    endtask

    task automatic exec_path(input int k, input logic [5:0] op, input logic [5:0] fn, input bit z);
        foreach (path[i]) begin
            opcode[k] = op; funct[k] = fn; zero[k] = z; mem_ready[k] = path[i].rdy;
            @(negedge clk);
            check_val("state", state_of(k), 32'(path[i].st));
            check_val("outputs", obs(k), exp_outs(path[i].st, op == OP_ZERO, fn_op(fn), z,
                      path[i].rdy, path[i].ill, path[i].ret, berr[k], 0));
            check_val("retired_count", cnt_of(k), exp_cnt[k] & cnt_mask(k));
            if (path[i].ret) exp_cnt[k] = exp_cnt[k] + 1;
            if (path[i].to) berr[k] = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn, input bit z,
                             input int fd, input int md, output bit faulted);
        build_path(k, op, fn, fd, md, faulted);
        exec_path(k, op, fn, z);
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1; mem_ready[k] = 1; opcode[k] = OP_SW; funct[k] = FN_ADD;
        exp_cnt[k] = 0; berr[k] = 0;
        @(negedge clk);
        check_val("rst_state", state_of(k), 0);
        check_val("rst_outputs", obs(k), exp_outs(0, 0, ALU_ADD, 0, 1, 0, 0, 0, 1));
        check_val("rst_count", cnt_of(k), 0);
        @(posedge clk); #1;
        rst[k] = 0;
    endtask

    logic [11:0] tbl [16];

    task automatic random_block(input int k, input int n, input int max_delay);
        bit f;
        logic [5:0] op, fn;
        for (int i = 0; i < n; i++) begin
            {op, fn} = tbl[$urandom_range(0, 15)];
            if (op != OP_ZERO) fn = 6'($urandom);
            run_instr(k, op, fn, rbit(), $urandom_range(0, max_delay),
                      $urandom_range(0, max_delay), f);
            if (f) do_reset(k);
        end
    endtask

    initial begin
        bit f;
        tbl = '{{OP_ZERO, FN_ADD}, {OP_ZERO, FN_SUB}, {OP_ZERO, FN_AND}, {OP_ZERO, FN_OR},
                {OP_ZERO, FN_XOR}, {OP_ZERO, FN_SLT}, {OP_ZERO, FN_ZERO}, {OP_LW, 6'h00},
                {OP_SW, 6'h00}, {OP_BEQ, 6'h00}, {OP_ADDI, 6'h00}, {OP_ADDIU, 6'h00},
                {OP_J, 6'h00}, {OP_ABS, 6'h00}, {6'h3F, 6'h00}, {OP_ZERO, 6'h3F}};
        rst = 2'b11; zero = 2'b00; mem_ready = 2'b00;
        for (int k = 0; k < 2; k++) begin
            opcode[k] = OP_ZERO; funct[k] = FN_ZERO; exp_cnt[k] = 0; berr[k] = 0;
        end
        @(posedge clk); #1;

        do_reset(0);
        run_instr(0, OP_ZERO, FN_ADD, 0, 0, 0, f);
        check_val("radd_count", cnt_of(0), 1);
        run_instr(0, OP_LW, 6'h00, 0, 0, 3, f);
        run_instr(0, OP_BEQ, 6'h00, 1, 0, 0, f);
        run_instr(0, OP_BEQ, 6'h00, 0, 0, 0, f);
        check_val("beq_count", cnt_of(0), 4);
        run_instr(0, 6'h3F, 6'h00, 0, 0, 0, f);
        check_val("illegal_trap", {31'b0, f}, 1);
        do_reset(0);

        path.delete();
        push_step(0, 1, 0, 0, 0);
        push_step(1, 1, 0, 0, 0);
        push_step(2, 0, 0, 0, 0);
        exec_path(0, OP_SW, 6'h00, 0);
        opcode[0] = OP_SW; mem_ready[0] = 0;
        @(negedge clk);
        check_val("memwr_state", state_of(0), 5);
        check_val("memwr_we", {31'b0, a_mem_we}, 1);
        #2 rst[0] = 1;
        #1;
        check_val("abort_state", state_of(0), 0);
        check_val("abort_req", {31'b0, a_mem_req}, 1);
        check_val("abort_we", {31'b0, a_mem_we}, 0);
        @(posedge clk); #1;
        rst[0] = 0; exp_cnt[0] = 0; berr[0] = 0;

        random_block(0, 50, 3);
        rst[0] = 1;

        do_reset(1);
        run_instr(1, OP_ZERO, FN_ADD, 0, 10, 0, f);
        check_val("timeout_fault", {31'b0, f}, 1);
        check_val("bus_err_sticky", {31'b0, b_bus_err}, 1);
        do_reset(1);
        run_instr(1, OP_ZERO, FN_OR, 0, 3, 0, f);
        run_instr(1, OP_SW, 6'h00, 0, 0, 3, f);
        run_instr(1, 6'h3F, 6'h00, 0, 0, 0, f);
        check_val("illegal_notrap_count", cnt_of(1), 3);
        do_reset(1);
        for (int i = 0; i < 16; i++) run_instr(1, OP_J, 6'h00, 0, 0, 0, f);
        check_val("count_wrap", cnt_of(1), 0);
        random_block(1, 50, 5);
        rst[1] = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
